// File: rtl/frame_scan_ctrl.sv
// rtl/frame_scan_ctrl.sv - raster-scan controller: pixel addressing, line-buffer selects, KxK window flags
module frame_scan_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int K      = 3,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              lb_wr_en,
    output logic [1:0]        lb_sel,
    output logic              win_valid,
    output logic [9:0]        win_row,
    output logic [9:0]        win_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
    localparam logic [9:0] KM1      = 10'(K - 1);
    localparam logic [1:0] LB_LAST  = 2'(K - 1);

    state_t            state_q, state_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        col_q, col_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        lb_sel_q, lb_sel_d;
    logic              win_valid_q, win_valid_d;
    logic [9:0]        win_row_q, win_row_d;
    logic [9:0]        win_col_q, win_col_d;
    logic              win_cond;
    logic              accept;

    // Fill pixels never wait on the MAC array; window-producing pixels do.
    assign win_cond = (row_q >= KM1) && (col_q >= KM1);
    assign in_ready = (state_q == S_SCAN) && (!win_cond || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rd_addr_q   <= '0;
            lb_sel_q    <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_addr_q   <= rd_addr_d;
            lb_sel_q    <= lb_sel_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_addr_d   = rd_addr_q;
        lb_sel_d    = lb_sel_q;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SCAN;
                    row_d     = '0;
                    col_d     = '0;
                    rd_addr_d = '0;
                    lb_sel_d  = '0;
                end
            end
            S_SCAN: begin
                if (accept) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        // Last pixel: park counters at zero so the address never runs past the frame.
                        if (row_q == ROW_LAST) begin
                            state_d   = S_DONE;
                            row_d     = '0;
                            rd_addr_d = '0;
                            lb_sel_d  = '0;
                        end else begin
                            row_d    = row_q + 10'd1;
                            lb_sel_d = (lb_sel_q == LB_LAST) ? 2'd0 : lb_sel_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                    if (win_cond) begin
                        win_valid_d = 1'b1;
                        win_row_d   = row_q - KM1;
                        win_col_d   = col_q - KM1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr   = rd_addr_q;
    assign lb_wr_en  = accept;
    assign lb_sel    = lb_sel_q;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb/tb_frame_scan_ctrl.sv - randomized bench for frame_scan_ctrl against a pixel-index reference model
module tb_frame_scan_ctrl;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int K      = 3;
    localparam int ADDR_W = 5;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWIN   = (IMG_W - K + 1) * (IMG_H - K + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              lb_wr_en;
    logic [1:0]        lb_sel;
    logic              win_valid;
    logic [9:0]        win_row;
    logic [9:0]        win_col;
    logic              busy;
    logic              done;

    frame_scan_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .rd_addr(rd_addr), .lb_wr_en(lb_wr_en), .lb_sel(lb_sel),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: frame progress is just the count of accepted pixels.
    int m_ph;   // 0 idle, 1 scanning, 2 done
    int m_n;
    int m_wv, m_wr, m_wc;
    int acc_cnt, win_cnt, done_cnt;
    int first_wr, first_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_n = 0; m_wv = 0; m_wr = 0; m_wc = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_lb_wr_en", 32'(lb_wr_en), 0);
        chk("rst_lb_sel", 32'(lb_sel), 0);
        chk("rst_win_valid", 32'(win_valid), 0);
        chk("rst_win_row", 32'(win_row), 0);
        chk("rst_win_col", 32'(win_col), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
    endtask

    task automatic tick(input logic s, input logic iv, input logic orr);
        int row, col, e_ready, e_acc, wcond;
        start = s; in_valid = iv; out_ready = orr;
        @(negedge clk);
        row = m_n / IMG_W;
        col = m_n % IMG_W;
        wcond = (row >= K - 1 && col >= K - 1) ? 1 : 0;
        e_ready = (m_ph == 1 && (wcond == 0 || orr)) ? 1 : 0;
        e_acc = (iv && e_ready != 0) ? 1 : 0;
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("lb_wr_en", 32'(lb_wr_en), 32'(e_acc));
        chk("rd_addr", 32'(rd_addr), 32'(m_n));
        chk("lb_sel", 32'(lb_sel), 32'(row % K));
        chk("win_valid", 32'(win_valid), 32'(m_wv));
        if (m_wv != 0) begin
            chk("win_row", 32'(win_row), 32'(m_wr));
            chk("win_col", 32'(win_col), 32'(m_wc));
        end
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("done", 32'(done), 32'(m_ph == 2));
        if (lb_wr_en) acc_cnt++;
        if (done) done_cnt++;
        if (win_valid) begin
            if (win_cnt == 0) begin
                first_wr = int'(win_row);
                first_wc = int'(win_col);
            end
            win_cnt++;
        end
        m_wv = (e_acc != 0 && wcond != 0) ? 1 : 0;
        if (m_wv != 0) begin
            m_wr = row - (K - 1);
            m_wc = col - (K - 1);
        end
        case (m_ph)
            0: if (s) begin m_ph = 1; m_n = 0; end
            1: if (e_acc != 0) begin
                if (m_n == NPIX - 1) begin m_ph = 2; m_n = 0; end
                else m_n++;
            end
            default: m_ph = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    // mode 0: full stream, 1: in_valid toggles, 2: stall at (2,4) plus mid-frame start, 3: random
    task automatic run_frame(input int mode, input string name);
        int stall_left = 5;
        int cyc = 0;
        logic iv, orr, s;
        tick(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        acc_cnt = 0; win_cnt = 0; done_cnt = 0; first_wr = -1; first_wc = -1;
        while (done_cnt == 0 && cyc < 600) begin
            iv = 1'b1; orr = 1'b1; s = 1'b0;
            case (mode)
                1: iv = 1'(cyc % 2 == 0);
                2: begin
                    if (m_n / IMG_W < K - 1) orr = 1'b0;
                    if (m_n == 20 && stall_left > 0) begin orr = 1'b0; stall_left--; end
                    if (m_n == 10) s = 1'b1;
                end
                3: begin
                    iv = 1'($urandom_range(0, 3) != 0);
                    orr = 1'($urandom_range(0, 2) != 0);
                    s = 1'($urandom_range(0, 7) == 0);
                end
                default: ;
            endcase
            tick(s, iv, orr);
            cyc++;
        end
        chk({name, "_done_cnt"}, 32'(done_cnt), 1);
        chk({name, "_accepts"}, 32'(acc_cnt), NPIX);
        chk({name, "_windows"}, 32'(win_cnt), NWIN);
        chk({name, "_first_win_row"}, 32'(first_wr), 0);
        chk({name, "_first_win_col"}, 32'(first_wc), 0);
        if (mode == 2) chk("stall_cycles_used", 32'(stall_left), 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        run_frame(0, "full");
        run_frame(1, "toggle");
        run_frame(2, "stall");

        // Reset in the middle of a frame, at rd_addr 17.
        tick(1'b1, 1'b0, 1'b1);
        done_cnt = 0;
        guard = 0;
        while (m_n != 17 && guard < 100) begin
            tick(1'b0, 1'b1, 1'b1);
            guard++;
        end
        chk("reached_addr17", 32'(rd_addr), 17);
        reset = 1'b1;
        #1;
        chk_reset_vals();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);
        chk("no_done_after_reset", 32'(done_cnt), 0);

        for (int f = 0; f < 4; f++) run_frame(3, "random");
        run_frame(0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_scan_ctrl.md
# frame_scan_ctrl

Raster-scan controller for one convolution layer input frame of the UAV detector. It accepts a stream of IMG_W × IMG_H pixels via a valid/ready handshake and generates the linear read address, row/column position and line-buffer write selects. It flags each position where a full K × K window is available, so the line buffers and MAC array can be sequenced from one place. The block sits between the frame memory reader and the line-buffer/convolution datapath and replaces ad-hoc per-row counters.

## Interface
- IMG_W, 640, pixels per row
- IMG_H, 640, rows per frame
- K, 3, convolution kernel size (window K × K, no padding, stride 1)
- ADDR_W, 19, width of linear pixel address (must satisfy 2^ADDR_W ≥ IMG_W·IMG_H)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request to scan one frame; ignored unless IDLE
- in_valid  in  1  upstream pixel present
- in_ready  out  1  block accepts pixel this cycle (combinational)
- out_ready  in  1  downstream MAC array can take a window this cycle
- rd_addr  out  ADDR_W  linear address of the next pixel to accept, row·IMG_W + col
- lb_wr_en  out  1  write accepted pixel into line buffer (= in_valid & in_ready)
- lb_sel  out  2  line buffer receiving the current row, rotates 0..K-1
- win_valid  out  1  registered; a complete window ends at the last accepted pixel
- win_row  out  10  registered; top row of that window (row − (K−1))
- win_col  out  10  registered; left column of that window (col − (K−1))
- busy  out  1  high in SCAN and DONE states
- done  out  1  one-cycle pulse after the last pixel of the frame is accepted

## Operation
- States: IDLE → SCAN (on start) → DONE (on accept of pixel row=IMG_H−1, col=IMG_W−1) → IDLE (unconditionally, next cycle).
- accept = in_valid & in_ready. win_cond = (row ≥ K−1) & (col ≥ K−1) for the current (row, col).
- in_ready = (state==SCAN) & (~win_cond | out_ready). Fill pixels never wait on downstream; window-producing pixels do.
- On accept: rd_addr += 1. col += 1, or col wraps to 0 at IMG_W−1 with row += 1. lb_sel increments mod K at each row wrap.
- On accept with win_cond: next cycle win_valid=1 with win_row=row−(K−1) and win_col=col−(K−1). Otherwise win_valid=0 next cycle.
- Windows per frame = (IMG_W−K+1)·(IMG_H−K+1). The default is 638·638 = 407044.
- Entering SCAN from IDLE clears row, col, rd_addr and lb_sel to 0.
- start while busy has no effect. start with in_valid in the same cycle does not accept; the first accept is possible one cycle later.
- Counter widths: row/col 10 bits; rd_addr ADDR_W bits and never exceeds IMG_W·IMG_H−1 before DONE.

## Timing
- Reset values: state IDLE, in_ready 0, rd_addr 0, lb_wr_en 0, lb_sel 0, win_valid 0, win_row 0, win_col 0, busy 0, done 0.
- start at cycle t → busy=1 and in_ready may go high at t+1.
- Window latency: 1 cycle from accept to win_valid.
- done and the final win_valid assert in the same cycle, 1 cycle after the last accept, with busy=1. busy=0 from the following cycle.
- out_ready low while win_cond is true: in_ready=0, and row, col and rd_addr hold. win_valid=0 during the stall.
- Reset mid-frame: all outputs return to reset values immediately, with no done pulse. A new start is required.
- Back-to-back frames: start is accepted in the cycle after DONE (state IDLE).

## Test plan
- IMG_W=8, IMG_H=4, K=3, in_valid and out_ready held high, start pulse → 32 accepts on consecutive cycles, 12 win_valid pulses, first at (win_row 0, win_col 0) 1 cycle after the accept of (2,2), done 1 cycle after rd_addr 31 is accepted.
- Same parameters, in_valid toggling 1/0 → exactly 32 lb_wr_en pulses, rd_addr strictly sequential 0..31, lb_sel pattern 0,1,2,0 per row.
- out_ready=0 for 5 cycles while at (2,4) → in_ready=0 and rd_addr holds at 20. Rows 0–1 fill pixels earlier are unaffected by out_ready=0.
- start pulsed at mid-frame → ignored, counters continue; reset asserted at rd_addr 17 → all outputs 0 next edge, no done; restart completes a full frame.
- Default parameters, full stream → 409600 accepts, 407044 windows, last window (637,637), done exactly once.
- Two frames back-to-back, with start in the cycle after done → second frame rd_addr restarts at 0, and lb_sel restarts at 0.
